project_mux_ctrl: RTL and testbench

Parametrised project multiplexer and Wishbone control block for the user area. It routes one of `NUM_PROJ` projects to the shared IO pads and holds a separate output-enable (OEB) word for each project. On every project switch it runs a sequence: isolate the pads, hold the newly selected project in reset, then connect it. Non-selected projects see all-zero inputs. Project cores sit outside this block; they are wired through flat buses and a per-project reset vector.

---
 rtl/project_mux_ctrl_if.sv | 21 ++
 rtl/project_mux_ctrl.sv | 164 ++++++++++++++++
 tb/tb_project_mux_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/project_mux_ctrl_if.sv
// Wishbone slave bus between the management SoC and the project multiplexer.
interface project_mux_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_mux_ctrl.sv
// Routes one of NUM_PROJ projects to the shared pads, with per-project OEB words
// and an isolate / hold-in-reset / connect sequence on every switch.
module project_mux_ctrl #(
    parameter int unsigned NUM_PROJ   = 6,
    parameter int unsigned IO_W       = 38,
    parameter logic [31:0] BASE       = 32'h3000_0000,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    project_mux_ctrl_if.slave        wb,
    input  logic [IO_W-1:0]          io_in,
    output logic [IO_W-1:0]          io_out,
    output logic [IO_W-1:0]          io_oeb,
    input  logic [NUM_PROJ*IO_W-1:0] proj_io_out,
    output logic [NUM_PROJ*IO_W-1:0] proj_io_in,
    output logic [NUM_PROJ-1:0]      proj_reset
);
    localparam int unsigned HI_W  = IO_W - 32;
    localparam int unsigned IDX_W = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;

    typedef enum logic [1:0] {
        ISOLATE   = 2'd0,
        HOLD      = 2'd1,
        CONNECTED = 2'd2,
        PARKED    = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      active;
    logic [7:0]      target;
    logic [7:0]      cnt;
    logic [15:0]     switches;
    logic            ack;
    logic            done;
    logic [7:0]      radr;
    logic [IO_W-1:0] oeb [NUM_PROJ];

    logic            valid;
    logic            in_window;
    logic [7:0]      off;
    logic            hit;
    logic            wr;
    logic            act_wr;
    logic [7:0]      new_act;
    logic            busy;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] tidx;
    logic [31:0]     rdata;

    function automatic logic is_oeb(input logic [7:0] o);
        return (o >= 8'h40) && (o[1:0] == 2'b00) && (32'(5'((o - 8'h40) >> 3)) < NUM_PROJ);
    endfunction

    function automatic logic [IDX_W-1:0] oeb_idx(input logic [7:0] o);
        return IDX_W'((o - 8'h40) >> 3);
    endfunction

    // Request decode; done blocks a second ack while the master keeps valid high
    always_comb begin
        valid     = wb.wbs_cyc_i & wb.wbs_stb_i;
        in_window = (wb.wbs_adr_i[31:8] == BASE[31:8]);
        off       = wb.wbs_adr_i[7:0];
        hit       = valid & in_window & ~ack & ~done;
        wr        = hit & wb.wbs_we_i;
        act_wr    = wr && (off == 8'h00) && wb.wbs_sel_i[0];
        new_act   = wb.wbs_dat_i[7:0];
        widx      = oeb_idx(off);
        ridx      = oeb_idx(radr);
        tidx      = IDX_W'(target);
        busy      = (state == ISOLATE) || (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ISOLATE;
            active   <= 8'd0;
            target   <= 8'd0;
            cnt      <= 8'(RST_CYCLES - 1);
            switches <= 16'd0;
            ack      <= 1'b0;
            done     <= 1'b0;
            radr     <= 8'd0;
            for (int p = 0; p < NUM_PROJ; p++) oeb[p] <= '1;
        end else begin
            ack  <= hit;
            done <= valid & (done | ack);
            if (hit) radr <= off;
            if (wr && is_oeb(off) && (wb.wbs_sel_i == 4'hF)) begin
                if (off[2]) oeb[widx][IO_W-1:32] <= wb.wbs_dat_i[HI_W-1:0];
                else        oeb[widx][31:0]      <= wb.wbs_dat_i;
            end
            if (act_wr) active <= new_act;

            case (state)
                ISOLATE: begin
                    cnt <= 8'(RST_CYCLES - 1);
                    if (act_wr)                       target <= new_act;
                    else if (32'(target) < NUM_PROJ)  state  <= HOLD;
                    else                              state  <= PARKED;
                end
                HOLD: begin
                    if (act_wr) begin
                        target <= new_act;
                        state  <= ISOLATE;
                    end else if (cnt == 8'd0) begin
                        state    <= CONNECTED;
                        switches <= switches + 16'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CONNECTED: begin
                    if (act_wr && (new_act != active)) begin
                        target <= new_act;
                        state  <= ISOLATE;
                    end
                end
                default: begin
                    if (act_wr) begin
                        target <= new_act;
                        state  <= ISOLATE;
                    end
                end
            endcase
        end
    end

    // Read data comes from the offset latched with the request and the post-edge state
    always_comb begin
        rdata = 32'd0;
        case (radr)
            8'h00:   rdata = {24'd0, active};
            8'h04:   rdata = {16'd0, target, 5'd0, state, busy};
            8'h08:   rdata = {16'd0, switches};
            default: begin
                if (is_oeb(radr))
                    rdata = radr[2] ? 32'(oeb[ridx][IO_W-1:32]) : oeb[ridx][31:0];
            end
        endcase
    end

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = ack ? rdata : 32'd0;

    // Pad routing: only a connected, in-range target sees the pads
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_io_in = '0;
        if ((state == CONNECTED) && (32'(target) < NUM_PROJ)) begin
            io_out = proj_io_out[int'(tidx)*IO_W +: IO_W];
            io_oeb = oeb[tidx];
            proj_io_in[int'(tidx)*IO_W +: IO_W] = io_in;
        end
    end

    always_comb begin
        proj_reset = '0;
        for (int i = 0; i < NUM_PROJ; i++)
            proj_reset[i] = reset | ((state == HOLD) && (target == 8'(i)));
    end
endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed bench for project_mux_ctrl with a read-data scoreboard queue.
module tb_project_mux_ctrl;
    localparam int unsigned NP   = 6;
    localparam int unsigned IOW  = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [63:0] ONES = 64'({IOW{1'b1}});

    logic              clk = 1'b0;
    logic              reset;
    logic [IOW-1:0]    io_in;
    logic [IOW-1:0]    io_out;
    logic [IOW-1:0]    io_oeb;
    logic [NP*IOW-1:0] proj_io_out;
    logic [NP*IOW-1:0] proj_io_in;
    logic [NP-1:0]     proj_reset;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    project_mux_ctrl_if wb ();

    project_mux_ctrl #(.NUM_PROJ(NP), .IO_W(IOW), .BASE(BASE), .RST_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .wb(wb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .proj_io_out(proj_io_out), .proj_io_in(proj_io_in), .proj_reset(proj_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic exp_ack,
                             input logic [31:0] exp_dat, input string tag);
        logic got;
        int   waited;
        logic [31:0] e;
        if (!we && exp_ack) exp_q.push_back(exp_dat);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
        got = 1'b0; waited = 0;
        while (!got && waited < 4) begin
            @(negedge clk);
            waited++;
            if (wb.wbs_ack_o) got = 1'b1;
        end
        if (got && !we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({"rd_", tag}, 64'(wb.wbs_dat_o), 64'(e));
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        chk({"ack_", tag}, 64'(got), 64'(exp_ack));
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel, input string tag);
        wb_access(1'b1, BASE + off, dat, sel, 1'b1, 32'd0, tag);
    endtask

    task automatic wb_rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        wb_access(1'b0, BASE + off, 32'd0, 4'hF, 1'b1, exp, tag);
    endtask

    task automatic check_connected(input int p, input logic [63:0] oeb_exp, input string tag);
        logic [IOW-1:0] slice;
        chk({tag, "_io_out"}, 64'(io_out), 64'(proj_io_out[p*IOW +: IOW]));
        chk({tag, "_io_oeb"}, 64'(io_oeb), oeb_exp);
        for (int q = 0; q < NP; q++) begin
            slice = proj_io_in[q*IOW +: IOW];
            chk($sformatf("%s_pin%0d", tag, q), 64'(slice), (q == p) ? 64'(io_in) : 64'd0);
        end
    endtask

    task automatic check_isolated(input string tag);
        chk({tag, "_io_out"}, 64'(io_out), 64'd0);
        chk({tag, "_io_oeb"}, 64'(io_oeb), ONES);
        chk({tag, "_pin_any"}, 64'(|proj_io_in), 64'd0);
    endtask

    initial begin
        int hold0, other, r3, r5, acks, bad;
        logic [31:0] e;
        reset = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0;
        io_in = IOW'({$urandom, $urandom});
        for (int p = 0; p < NP; p++) proj_io_out[p*IOW +: IOW] = IOW'({$urandom, $urandom});

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_proj_reset", 64'(proj_reset), 64'(6'h3F));
        chk("rst_io_oeb", 64'(io_oeb), ONES);
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("rst_dat", 64'(wb.wbs_dat_o), 64'd0);

        // Release: project 0 held for exactly four cycles, nobody else
        reset = 1'b0;
        hold0 = 0; other = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (proj_reset[0]) hold0++;
            if (proj_reset[NP-1:1] != '0) other++;
        end
        chk("boot_hold0", 64'(hold0), 64'd4);
        chk("boot_other", 64'(other), 64'd0);
        wb_rd(32'h04, 32'h0000_0004, "status_boot");
        wb_rd(32'h08, 32'd1, "switches_boot");
        wb_rd(32'h00, 32'd0, "active_boot");
        check_connected(0, ONES, "conn0");

        // OEB for project 2, then switch to it
        wb_wr(32'h50, 32'hFFFF_00FF, 4'hF, "oeb_lo2");
        wb_rd(32'h50, 32'hFFFF_00FF, "oeb_lo2");
        wb_wr(32'h00, 32'd2, 4'h1, "act2");
        bad = (io_oeb != IOW'(ONES)) ? 1 : 0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (io_oeb != IOW'(ONES) || io_out != '0) bad++;
        end
        chk("sw2_isolated", 64'(bad), 64'd0);
        @(negedge clk);
        check_connected(2, {26'd0, 6'h3F, 32'hFFFF_00FF}, "conn2");
        wb_rd(32'h08, 32'd2, "switches_2");
        wb_rd(32'h04, 32'h0000_0204, "status_2");

        // Live OEB update on the active project
        wb_wr(32'h50, 32'h1234_5678, 4'hF, "oeb_live");
        chk("oeb_live_pad", 64'(io_oeb), {26'd0, 6'h3F, 32'h1234_5678});

        // Retarget during HOLD
        wb_wr(32'h00, 32'd3, 4'h1, "act3");
        wb_wr(32'h00, 32'd5, 4'h1, "act5");
        chk("retarget_iso_rst", 64'(proj_reset), 64'd0);
        r3 = 0; r5 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (proj_reset[3]) r3++;
            if (proj_reset[5]) r5++;
        end
        chk("retarget_r3", 64'(r3), 64'd0);
        chk("retarget_r5", 64'(r5), 64'd4);
        check_connected(5, ONES, "conn5");
        wb_rd(32'h08, 32'd3, "switches_5");

        // Same-value write is a no-op
        wb_wr(32'h00, 32'd5, 4'h1, "act5_again");
        wb_rd(32'h04, 32'h0000_0504, "status_same");
        wb_rd(32'h08, 32'd3, "switches_same");

        // Park on an out-of-range project
        wb_wr(32'h00, 32'd9, 4'h1, "act9");
        repeat (2) @(negedge clk);
        wb_rd(32'h04, 32'h0000_0906, "status_park");
        check_isolated("park");
        chk("park_proj_reset", 64'(proj_reset), 64'd0);

        // Held request: a single ack
        exp_q.push_back(32'd3);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE + 32'h08; wb.wbs_sel_i = 4'hF;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) begin
                acks++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rd_held", 64'(wb.wbs_dat_o), 64'(e));
                end
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        chk("held_acks", 64'(acks), 64'd1);

        // Partial-select OEB write is acked but ignored
        wb_wr(32'h4C, 32'h0000_0000, 4'h3, "oeb_hi1_sel3");
        wb_rd(32'h4C, 32'h0000_003F, "oeb_hi1_keep");
        wb_rd(32'h20, 32'd0, "unmapped");

        // Outside the window: no ack, no state change
        wb_access(1'b1, BASE + 32'h100, 32'd1, 4'hF, 1'b0, 32'd0, "outside_wr");
        wb_access(1'b0, BASE + 32'h100, 32'd0, 4'hF, 1'b0, 32'd0, "outside_rd");
        wb_rd(32'h00, 32'd9, "active_after_outside");
        wb_rd(32'h04, 32'h0000_0906, "status_after_outside");

        // Leave park
        wb_wr(32'h00, 32'd1, 4'h1, "act1");
        repeat (6) @(negedge clk);
        wb_rd(32'h04, 32'h0000_0104, "status_1");
        wb_rd(32'h08, 32'd4, "switches_1");
        check_connected(1, ONES, "conn1");

        // Reset in the middle of a switch
        wb_wr(32'h00, 32'd4, 4'h1, "act4");
        @(negedge clk);
        chk("mid_hold4", 64'(proj_reset[4]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_proj_reset", 64'(proj_reset), 64'(6'h3F));
        check_isolated("mid_rst");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        wb_rd(32'h00, 32'd0, "active_after_rst");
        wb_rd(32'h08, 32'd1, "switches_after_rst");
        wb_rd(32'h54, 32'h0000_003F, "oeb_hi2_after_rst");
        check_connected(0, ONES, "conn0_again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
